// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (M0/M1) and memory-side signals for mem_port_arbiter.
// master: requesters plus memory model; slave: the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic          m0_err;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic          m1_err;

    logic [DW-1:0] rdata;
    logic [1:0]    grant;

    logic          mem_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m0_ack, m0_err, m1_ack, m1_err, rdata, grant,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m0_ack, m0_err, m1_ack, m1_err, rdata, grant,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one memory port: IDLE/BUSY/RESP FSM with timeout, all outputs registered.
// Optional ARB_ROUND_ROBIN_EN: ties go to the requester not granted last (else fixed FIXED_PRIO).
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 255,
    parameter int FIXED_PRIO = 0
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          mem_valid_q, mem_valid_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    grant_q, grant_d;
    logic          m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
    logic          m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;

    logic          any_req;
    logic          tie_m1;
    logic          pick_m1;
    logic [7:0]    cnt_inc;
    logic          timeout;

    assign any_req = bus.m0_req | bus.m1_req;
    assign pick_m1 = (bus.m0_req && bus.m1_req) ? tie_m1 : bus.m1_req;
    assign cnt_inc = cnt_q + 8'd1;
    // cnt_inc counts the current BUSY cycle, so mem_valid stays up exactly TIMEOUT cycles
    assign timeout = (cnt_inc == TO_LIMIT);

`ifdef ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;

    assign tie_m1 = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == RESP) ptr_d = ~owner_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= (FIXED_PRIO != 0);
        else      ptr_q <= ptr_d;
    end
`else
    assign tie_m1 = (FIXED_PRIO != 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (bus.mem_ready || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        grant_d     = grant_q;
        m0_ack_d    = 1'b0;
        m0_err_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m1_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d     = pick_m1;
                    mem_valid_d = 1'b1;
                    mem_we_d    = pick_m1 ? bus.m1_we    : bus.m0_we;
                    mem_addr_d  = pick_m1 ? bus.m1_addr  : bus.m0_addr;
                    mem_wdata_d = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
                    grant_d     = pick_m1 ? 2'b10 : 2'b01;
                    cnt_d       = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_inc;
                // ready on the timeout cycle still counts as a good completion
                if (bus.mem_ready || timeout) begin
                    mem_valid_d = 1'b0;
                    rdata_d     = (bus.mem_ready && !mem_we_q) ? bus.mem_rdata : '0;
                    m0_ack_d    = ~owner_q;
                    m1_ack_d    = owner_q;
                    m0_err_d    = ~owner_q & ~bus.mem_ready;
                    m1_err_d    = owner_q & ~bus.mem_ready;
                end
            end
            RESP: begin
                cnt_d       = '0;
                grant_d     = 2'b00;
                rdata_d     = '0;
                mem_we_d    = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            grant_q     <= 2'b00;
            m0_ack_q    <= 1'b0;
            m0_err_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m1_err_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            grant_q     <= grant_d;
            m0_ack_q    <= m0_ack_d;
            m0_err_q    <= m0_err_d;
            m1_ack_q    <= m1_ack_d;
            m1_err_q    <= m1_err_d;
        end
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.grant     = grant_q;
    assign bus.m0_ack    = m0_ack_q;
    assign bus.m0_err    = m0_err_q;
    assign bus.m1_ack    = m1_ack_q;
    assign bus.m1_err    = m1_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4, FIXED_PRIO=0); tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(4), .FIXED_PRIO(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [103:0] all_outs();
        return {bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err, bus.rdata,
                bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.grant};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
        tick(); tick();
        n_checks++;
        if (all_outs() !== 104'h0) begin
            n_fail++; $display("FAIL reset_outs: got %h expected 0", all_outs());
        end
        bus.m0_req = 1'b0; bus.mem_ready = 1'b0;
        rst = 1'b1;
        tick();
        n_checks++;
        if (all_outs() !== 104'h0) begin
            n_fail++; $display("FAIL reset_idle: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_tie();
        logic        exp_m1   [5];
        logic [31:0] exp_addr [5];
        logic [1:0]  exp_g;
`ifdef ARB_ROUND_ROBIN_EN
        exp_m1   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_addr = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h304};
`else
        exp_m1   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_addr = '{32'h100, 32'h200, 32'h300, 32'h304, 32'h400};
`endif
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h100;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h200;
        for (int k = 0; k < 5; k++) begin
            exp_g = exp_m1[k] ? 2'b10 : 2'b01;
            tick();
            n_checks++;
            if ({bus.grant, bus.mem_valid, bus.mem_addr} !== {exp_g, 1'b1, exp_addr[k]}) begin
                n_fail++;
                $display("FAIL tie_grant[%0d]: got grant=%b valid=%b addr=%h expected grant=%b valid=1 addr=%h",
                         k, bus.grant, bus.mem_valid, bus.mem_addr, exp_g, exp_addr[k]);
            end
            bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA000_0000 + k;
            tick();
            n_checks++;
            if ({bus.m1_ack, bus.m0_ack, bus.rdata} !== {exp_g, 32'hA000_0000 + k}) begin
                n_fail++;
                $display("FAIL tie_ack[%0d]: got acks=%b%b rdata=%h expected acks=%b rdata=%h",
                         k, bus.m1_ack, bus.m0_ack, bus.rdata, exp_g, 32'hA000_0000 + k);
            end
            bus.mem_ready = 1'b0;
            if (exp_m1[k]) bus.m1_req = 1'b0;
            else           bus.m0_req = 1'b0;
            tick();
            if (k == 1) begin
                bus.m0_req = 1'b1; bus.m0_addr = 32'h300;
                bus.m1_req = 1'b1; bus.m1_addr = 32'h400;
            end
            if (k == 2) begin
                bus.m0_req = 1'b1; bus.m0_addr = 32'h304;
            end
        end
        n_checks++;
        if ({bus.grant, bus.mem_valid, bus.m0_ack, bus.m1_ack} !== 5'b0) begin
            n_fail++; $display("FAIL tie_done: got grant=%b valid=%b expected idle", bus.grant, bus.mem_valid);
        end
    endtask

    task automatic test_single_read();
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10; bus.m0_wdata = 32'h0;
        tick();
        n_checks++;
        if ({bus.mem_valid, bus.mem_we, bus.mem_addr, bus.grant, bus.m0_ack} !== {1'b1, 1'b0, 32'h10, 2'b01, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_issue: got valid=%b we=%b addr=%h grant=%b ack=%b expected 1 0 00000010 01 0",
                     bus.mem_valid, bus.mem_we, bus.mem_addr, bus.grant, bus.m0_ack);
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
        tick();
        n_checks++;
        if ({bus.m0_ack, bus.m0_err, bus.m1_ack, bus.mem_valid, bus.rdata} !== {4'b1000, 32'hCAFE_0001}) begin
            n_fail++;
            $display("FAIL rd_ack: got ack=%b err=%b m1ack=%b valid=%b rdata=%h expected 1 0 0 0 cafe0001",
                     bus.m0_ack, bus.m0_err, bus.m1_ack, bus.mem_valid, bus.rdata);
        end
        bus.m0_req = 1'b0; bus.mem_ready = 1'b0;
        tick();
        n_checks++;
        if ({bus.m0_ack, bus.grant, bus.mem_valid} !== 4'b0) begin
            n_fail++; $display("FAIL rd_after: got ack=%b grant=%b valid=%b expected 0", bus.m0_ack, bus.grant, bus.mem_valid);
        end
    endtask

    task automatic test_write_wait();
        int acks;
        acks = 0;
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h20; bus.m1_wdata = 32'h55;
        bus.mem_rdata = 32'hDEAD_BEEF;
        for (int i = 1; i <= 4; i++) begin
            tick();
            acks += int'(bus.m1_ack);
            n_checks++;
            if ({bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.grant} !== {2'b11, 32'h20, 32'h55, 2'b10}) begin
                n_fail++;
                $display("FAIL wr_hold[%0d]: got valid=%b we=%b addr=%h wdata=%h grant=%b expected 1 1 00000020 00000055 10",
                         i, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.grant);
            end
            if (i == 4) bus.mem_ready = 1'b1;
        end
        tick();
        acks += int'(bus.m1_ack);
        n_checks++;
        if ({bus.m1_ack, bus.m1_err, bus.m0_ack, bus.mem_valid, bus.rdata} !== {4'b1000, 32'h0}) begin
            n_fail++;
            $display("FAIL wr_ack: got ack=%b err=%b m0ack=%b valid=%b rdata=%h expected 1 0 0 0 00000000",
                     bus.m1_ack, bus.m1_err, bus.m0_ack, bus.mem_valid, bus.rdata);
        end
        bus.m1_req = 1'b0; bus.mem_ready = 1'b0;
        tick();
        acks += int'(bus.m1_ack);
        n_checks++;
        if (acks != 1) begin
            n_fail++; $display("FAIL wr_ack_count: got %0d acks expected 1", acks);
        end
    endtask

    task automatic test_timeout();
        bus.mem_ready = 1'b1;
        tick();
        n_checks++;
        if ({bus.mem_valid, bus.m0_ack, bus.m1_ack, bus.grant} !== 5'b0) begin
            n_fail++; $display("FAIL idle_ready_ignored: got valid=%b acks=%b%b expected 0", bus.mem_valid, bus.m0_ack, bus.m1_ack);
        end
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h40;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if ({bus.mem_valid, bus.m0_ack} !== 2'b10) begin
                n_fail++; $display("FAIL to_wait[%0d]: got valid=%b ack=%b expected 1 0", i, bus.mem_valid, bus.m0_ack);
            end
        end
        tick();
        n_checks++;
        if ({bus.mem_valid, bus.m0_ack, bus.m0_err, bus.m1_ack, bus.rdata} !== {4'b0110, 32'h0}) begin
            n_fail++;
            $display("FAIL to_ack: got valid=%b ack=%b err=%b m1ack=%b rdata=%h expected 0 1 1 0 00000000",
                     bus.mem_valid, bus.m0_ack, bus.m0_err, bus.m1_ack, bus.rdata);
        end
        bus.m0_req = 1'b0;
        tick();
        n_checks++;
        if ({bus.m0_ack, bus.m0_err} !== 2'b00) begin
            n_fail++; $display("FAIL to_after: got ack=%b err=%b expected 0 0", bus.m0_ack, bus.m0_err);
        end
    endtask

    task automatic test_busy_reset();
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h500;
        tick();
        n_checks++;
        if (bus.mem_valid !== 1'b1) begin
            n_fail++; $display("FAIL br_busy: got valid=%b expected 1", bus.mem_valid);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (all_outs() !== 104'h0) begin
            n_fail++; $display("FAIL br_async: got %h expected 0", all_outs());
        end
        tick();
        rst = 1'b1;
        n_checks++;
        if ({bus.m0_ack, bus.mem_valid} !== 2'b00) begin
            n_fail++; $display("FAIL br_release: got ack=%b valid=%b expected 0 0", bus.m0_ack, bus.mem_valid);
        end
        tick();
        n_checks++;
        if ({bus.mem_valid, bus.mem_addr, bus.grant, bus.m0_ack} !== {1'b1, 32'h500, 2'b01, 1'b0}) begin
            n_fail++;
            $display("FAIL br_rearb: got valid=%b addr=%h grant=%b ack=%b expected 1 00000500 01 0",
                     bus.mem_valid, bus.mem_addr, bus.grant, bus.m0_ack);
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5A5A_5A5A;
        tick();
        n_checks++;
        if ({bus.m0_ack, bus.m0_err, bus.rdata} !== {2'b10, 32'h5A5A_5A5A}) begin
            n_fail++; $display("FAIL br_ack: got ack=%b err=%b rdata=%h expected 1 0 5a5a5a5a", bus.m0_ack, bus.m0_err, bus.rdata);
        end
        bus.m0_req = 1'b0; bus.mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_tie();
        test_single_read();
        test_write_wait();
        test_timeout();
        test_busy_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish by 50000 time units");
        $fatal(1);
    end
endmodule
